// File: rtl/plot_sink_pkg.sv
// Shared screen geometry, field widths, FSM state encoding and address helpers
// for the plot sink that sits in front of the framebuffer RAM.
package plot_sink_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CBITS   = 3;
    localparam int AW      = 15;
    localparam int EW      = XW + YW + CBITS;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        QRD,
        QWAIT
    } state_t;

    // y*160 + x without a multiplier: 160 = 128 + 32.
    function automatic logic [AW-1:0] xy_to_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [AW-1:0] y_ext;
        y_ext = AW'(y);
        return (y_ext << 7) + (y_ext << 5) + AW'(x);
    endfunction

    function automatic logic xy_in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < XW'(XSCREEN)) && (y < YW'(YSCREEN));
    endfunction

endpackage

// File: rtl/plot_sink_fb_fifo.sv
// Small synchronous FIFO holding pending plot requests {x, y, colour}.
// Head entry is readable combinationally so a drain write can issue every cycle.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset: only the pointers define which entries are live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge Clock) begin
                if (do_push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/plot_sink_fb.sv
// Plot sink: buffers pixel writes and drains them to the framebuffer RAM port,
// with a coherent colour read-back query. Define PLOT_DROP_CNT_EN for drop_cnt.
module plot_sink_fb
    import plot_sink_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  logic [CBITS-1:0]  colour,
    input  logic              plot,
    output logic              ready,
    input  logic [XW-1:0]     q_x,
    input  logic [YW-1:0]     q_y,
    input  logic              q_req,
    output logic              q_ready,
    output logic              q_valid,
    output logic [CBITS-1:0]  q_colour,
    output logic [AW-1:0]     mem_addr,
    output logic [CBITS-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [CBITS-1:0]  mem_rdata,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_reg;
    logic            started_reg;
    logic [AW-1:0]   q_addr_reg;
    logic            q_oor_reg;
    logic            q_valid_reg;
    logic [CBITS-1:0] q_colour_reg;

    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_dout;
    logic [CW-1:0]   fifo_remain;

    logic            plot_accept;
    logic            plot_in_range;
    logic            push;
    logic            pop;
    logic            q_accept;
    logic [CBITS-1:0] q_result;

    logic [XW-1:0]   head_x;
    logic [YW-1:0]   head_y;
    logic [CBITS-1:0] head_c;

    // started_reg keeps ready low until the first edge after reset release.
    assign ready         = started_reg && !fifo_full;
    assign plot_accept   = plot && ready;
    assign plot_in_range = xy_in_range(x, y);
    assign push          = plot_accept && plot_in_range;
    assign pop           = (state_reg == DRAIN) && !fifo_empty;
    assign fifo_remain   = fifo_count - CW'(pop) + CW'(push);

    // Queries only get in with an empty FIFO, so every earlier plot is already written.
    assign q_ready  = started_reg && q_req && (state_reg == IDLE) && fifo_empty;
    assign q_accept = q_ready;

    assign head_x = fifo_dout[EW-1 -: XW];
    assign head_y = fifo_dout[CBITS +: YW];
    assign head_c = fifo_dout[CBITS-1:0];

    assign busy = !fifo_empty || (state_reg != IDLE);

    plot_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .Clock  (Clock),
        .Resetn (Resetn),
        .push   (push),
        .din    ({x, y, colour}),
        .pop    (pop),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Read data arrives during QWAIT; it is presented directly and captured for holding.
    assign q_result = q_oor_reg ? '0 : mem_rdata;
    assign q_colour = (state_reg == QWAIT) ? q_result : q_colour_reg;
    assign q_valid  = q_valid_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg    <= IDLE;
            started_reg  <= 1'b0;
            q_addr_reg   <= '0;
            q_oor_reg    <= 1'b0;
            q_valid_reg  <= 1'b0;
            q_colour_reg <= '0;
        end else begin
            started_reg <= 1'b1;
            q_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_reg <= DRAIN;
                    end else if (q_accept) begin
                        q_addr_reg <= xy_to_addr(q_x, q_y);
                        q_oor_reg  <= !xy_in_range(q_x, q_y);
                        state_reg  <= QRD;
                    end
                end
                DRAIN: begin
                    if (fifo_remain == '0) begin
                        state_reg <= IDLE;
                    end
                end
                QRD: begin
                    q_valid_reg <= 1'b1;
                    state_reg   <= QWAIT;
                end
                QWAIT: begin
                    q_colour_reg <= q_result;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // RAM port is decoded from state so a write lands in the DRAIN cycle itself.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_reg)
            DRAIN: begin
                mem_we = pop;
                if (pop) begin
                    mem_addr  = xy_to_addr(head_x, head_y);
                    mem_wdata = head_c;
                end
            end
            QRD: begin
                if (!q_oor_reg) begin
                    mem_addr = q_addr_reg;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef PLOT_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            drop_cnt_reg <= '0;
        end else if (plot_accept && !plot_in_range && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_plot_sink_fb.sv
// Self-checking bench for plot_sink_fb: scoreboard of expected RAM writes and
// query results, compared per scenario against what the monitor observed.
module tb_plot_sink_fb;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic [7:0]  x, q_x;
    logic [6:0]  y, q_y;
    logic [2:0]  colour, q_colour, mem_wdata, mem_rdata;
    logic        plot, ready, q_req, q_ready, q_valid, mem_we, busy;
    logic [14:0] mem_addr;
    logic [7:0]  drop_cnt;

    logic [2:0]  fb [0:32767];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

`ifdef PLOT_DROP_CNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    typedef struct { int a; int d; int c; } wr_t;
    typedef struct { int d; int c; } qr_t;

    wr_t obs_w[$];
    wr_t exp_w[$];
    qr_t obs_q[$];
    int  exp_q[$];

    always #5 Clock = ~Clock;

    plot_sink_fb #(.DEPTH(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .ready     (ready),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_req     (q_req),
        .q_ready   (q_ready),
        .q_valid   (q_valid),
        .q_colour  (q_colour),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always @(posedge Clock) cyc <= cyc + 1;

    // Framebuffer RAM model: synchronous read, data one cycle after the address.
    always @(posedge Clock) begin
        if (mem_we === 1'b1) fb[mem_addr] <= mem_wdata;
        mem_rdata <= fb[mem_addr];
    end

    always @(negedge Clock) begin
        wr_t w;
        qr_t r;
        if (mem_we === 1'b1) begin
            w.a = int'(mem_addr); w.d = int'(mem_wdata); w.c = cyc;
            obs_w.push_back(w);
            $display("write addr=%0d data=%0d cycle=%0d", w.a, w.d, w.c);
        end
        if (q_valid === 1'b1) begin
            r.d = int'(q_colour); r.c = cyc;
            obs_q.push_back(r);
            $display("query colour=%0d cycle=%0d", r.d, r.c);
        end
    end

    task automatic send_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc,
                             output int acc_cyc);
        wr_t w;
        @(posedge Clock); #1;
        x = px; y = py; colour = pc; plot = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 50 && acc_cyc < 0; i++) begin
            @(negedge Clock);
            if (ready === 1'b1) acc_cyc = cyc;
            @(posedge Clock); #1;
        end
        plot = 1'b0;
        if (acc_cyc < 0) begin
            n_checks++;
            $display("FAIL plot_accept_timeout: x=%0d y=%0d never accepted, required accept", px, py);
        end else if (px < 160 && py < 120) begin
            w.a = int'(py) * 160 + int'(px); w.d = int'(pc); w.c = acc_cyc;
            exp_w.push_back(w);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        @(negedge Clock);
        while (busy !== 1'b0 && t < 200) begin
            @(negedge Clock);
            t++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle: busy=%b required 0", tag, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        x = '0; y = '0; colour = '0; plot = 1'b0;
        q_x = '0; q_y = '0; q_req = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        n_checks++;
        if ({ready, q_ready, q_valid, mem_we, busy} !== 5'b0)
            $display("FAIL reset_flags: ready/q_ready/q_valid/mem_we/busy=%b required 00000",
                     {ready, q_ready, q_valid, mem_we, busy});
        else n_pass++;
        n_checks++;
        if (q_colour !== 3'd0 || mem_addr !== 15'd0 || mem_wdata !== 3'd0)
            $display("FAIL reset_data: q_colour=%0d mem_addr=%0d mem_wdata=%0d required 0 0 0",
                     q_colour, mem_addr, mem_wdata);
        else n_pass++;
        n_checks++;
        if (drop_cnt !== 8'd0) $display("FAIL reset_drop: drop_cnt=%0d required 0", drop_cnt);
        else n_pass++;
        Resetn = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL reset_release_ready: ready=%b required 1", ready);
        else n_pass++;
    endtask

    task automatic test_single_plot();
        int  acc;
        wr_t e, o;
        obs_w.delete(); exp_w.delete();
        send_plot(8'd5, 7'd3, 3'b101, acc);
        wait_idle("single");
        n_checks++;
        if (obs_w.size() != 1) $display("FAIL single_count: writes=%0d required 1", obs_w.size());
        else n_pass++;
        if (obs_w.size() > 0 && exp_w.size() > 0) begin
            e = exp_w.pop_front(); o = obs_w.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL single_write: addr=%0d data=%0d required addr=%0d data=%0d", o.a, o.d, e.a, e.d);
            else n_pass++;
            n_checks++;
            if (o.c !== acc + 2) $display("FAIL single_latency: write cycle=%0d required %0d", o.c, acc + 2);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int   idx, first_stall, t;
        logic pacc, qacc;
        wr_t  w, e, o;
        qr_t  r;
        obs_w.delete(); exp_w.delete(); obs_q.delete(); exp_q.delete();
        @(posedge Clock); #1;
        idx = 0; first_stall = -1; t = 0;
        q_x = 8'd150; q_y = 7'd100; q_req = 1'b1;
        exp_q.push_back(0);
        x = 8'd20; y = 7'd30; colour = 3'd1; plot = 1'b1;
        while ((plot || q_req) && t < 60) begin
            @(negedge Clock);
            qacc = q_req && q_ready;
            pacc = plot && ready;
            if (plot && !ready && first_stall < 0) first_stall = idx;
            if (pacc) begin
                w.a = int'(y) * 160 + int'(x); w.d = int'(colour); w.c = cyc;
                exp_w.push_back(w);
                idx++;
            end
            @(posedge Clock); #1;
            t++;
            if (qacc) q_req = 1'b0;
            if (pacc) begin
                if (idx < 6) begin
                    x = 8'(20 + idx); y = 7'(30 + idx); colour = 3'(idx + 1);
                end else begin
                    plot = 1'b0;
                end
            end
        end
        plot = 1'b0; q_req = 1'b0;
        n_checks++;
        if (idx != 6) $display("FAIL b2b_accepts: accepted=%0d required 6", idx);
        else n_pass++;
        n_checks++;
        if (first_stall != 4) $display("FAIL b2b_stall_point: ready dropped after %0d accepts, required 4", first_stall);
        else n_pass++;
        wait_idle("b2b");
        n_checks++;
        if (obs_w.size() != exp_w.size())
            $display("FAIL b2b_count: writes=%0d required %0d", obs_w.size(), exp_w.size());
        else n_pass++;
        while (obs_w.size() > 0 && exp_w.size() > 0) begin
            e = exp_w.pop_front(); o = obs_w.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL b2b_write: addr=%0d data=%0d required addr=%0d data=%0d", o.a, o.d, e.a, e.d);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL b2b_query_count: results=%0d required 1", obs_q.size());
        else begin
            r = obs_q.pop_front();
            if (r.d !== exp_q.pop_front()) $display("FAIL b2b_query_colour: colour=%0d required 0", r.d);
            else n_pass++;
        end
    endtask

    task automatic test_boundary();
        int  acc;
        wr_t e, o;
        obs_w.delete(); exp_w.delete();
        send_plot(8'd0,   7'd0,   3'd7, acc);
        send_plot(8'd159, 7'd119, 3'd6, acc);
        send_plot(8'd160, 7'd0,   3'd1, acc);
        wait_idle("boundary");
        n_checks++;
        if (obs_w.size() != 2) $display("FAIL boundary_count: writes=%0d required 2", obs_w.size());
        else n_pass++;
        while (obs_w.size() > 0 && exp_w.size() > 0) begin
            e = exp_w.pop_front(); o = obs_w.pop_front();
            n_checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL boundary_write: addr=%0d data=%0d required addr=%0d data=%0d", o.a, o.d, e.a, e.d);
            else n_pass++;
        end
        n_checks++;
        if (drop_cnt !== 8'(EXP_DROP)) $display("FAIL boundary_drop: drop_cnt=%0d required %0d", drop_cnt, EXP_DROP);
        else n_pass++;
    endtask

    task automatic test_coherence();
        int  acc, qacc;
        wr_t e, o;
        qr_t r;
        obs_w.delete(); exp_w.delete(); obs_q.delete(); exp_q.delete();
        send_plot(8'd10, 7'd10, 3'b010, acc);
        q_x = 8'd10; q_y = 7'd10; q_req = 1'b1;
        exp_q.push_back(2);
        qacc = -1;
        for (int i = 0; i < 50 && qacc < 0; i++) begin
            @(negedge Clock);
            if (q_ready === 1'b1) qacc = cyc;
            @(posedge Clock); #1;
        end
        q_req = 1'b0;
        wait_idle("coherence");
        n_checks++;
        if (qacc < 0) $display("FAIL coherence_q_accept: query never accepted, required accept");
        else n_pass++;
        n_checks++;
        if (obs_w.size() != 1) $display("FAIL coherence_count: writes=%0d required 1", obs_w.size());
        else begin
            e = exp_w.pop_front(); o = obs_w.pop_front();
            if (o.a !== e.a || o.d !== e.d || o.c >= qacc)
                $display("FAIL coherence_write: addr=%0d data=%0d cycle=%0d required addr=%0d data=%0d before cycle %0d",
                         o.a, o.d, o.c, e.a, e.d, qacc);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL coherence_q_count: results=%0d required 1", obs_q.size());
        else begin
            r = obs_q.pop_front();
            if (r.d !== exp_q[0] || r.c !== qacc + 2)
                $display("FAIL coherence_q_result: colour=%0d cycle=%0d required colour=%0d cycle=%0d",
                         r.d, r.c, exp_q[0], qacc + 2);
            else n_pass++;
        end
    endtask

    task automatic test_oor_query();
        int   qacc;
        logic touched;
        qr_t  r;
        obs_w.delete(); obs_q.delete();
        @(posedge Clock); #1;
        q_x = 8'd200; q_y = 7'd5; q_req = 1'b1;
        qacc = -1; touched = 1'b0;
        for (int i = 0; i < 20 && qacc < 0; i++) begin
            @(negedge Clock);
            if (q_ready === 1'b1) qacc = cyc;
            @(posedge Clock); #1;
        end
        q_req = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            if (mem_we !== 1'b0 || mem_addr !== 15'd0) touched = 1'b1;
        end
        n_checks++;
        if (qacc < 0) $display("FAIL oor_accept: query never accepted, required accept");
        else n_pass++;
        n_checks++;
        if (touched !== 1'b0 || obs_w.size() != 0)
            $display("FAIL oor_mem_access: touched=%b writes=%0d required 0 0", touched, obs_w.size());
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 1) $display("FAIL oor_count: results=%0d required 1", obs_q.size());
        else begin
            r = obs_q.pop_front();
            if (r.d !== 0 || r.c !== qacc + 2)
                $display("FAIL oor_result: colour=%0d cycle=%0d required colour=0 cycle=%0d", r.d, r.c, qacc + 2);
            else n_pass++;
        end
        n_checks++;
        if (q_colour !== 3'd0) $display("FAIL oor_hold: q_colour=%0d required 0", q_colour);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        int accepts;
        obs_w.delete(); exp_w.delete(); obs_q.delete();
        @(posedge Clock); #1;
        accepts = 0;
        x = 8'd40; y = 7'd50; colour = 3'd3; plot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            if (ready === 1'b1) accepts++;
            if (i < 2) begin
                @(posedge Clock); #1;
                x = 8'(41 + i); y = 7'(51 + i); colour = 3'(4 + i);
            end
        end
        n_checks++;
        if (mem_we !== 1'b1 || accepts != 3)
            $display("FAIL drain_rst_setup: mem_we=%b accepts=%0d required 1 3", mem_we, accepts);
        else n_pass++;
        #1;
        Resetn = 1'b0; plot = 1'b0;
        #1;
        n_checks++;
        if ({mem_we, ready, busy, q_valid} !== 4'b0)
            $display("FAIL drain_rst_immediate: mem_we/ready/busy/q_valid=%b required 0000",
                     {mem_we, ready, busy, q_valid});
        else n_pass++;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL drain_rst_release: ready=%b busy=%b mem_we=%b required 1 0 0", ready, busy, mem_we);
        else n_pass++;
        repeat (10) @(negedge Clock);
        n_checks++;
        if (obs_w.size() != 1 || obs_w[0].a != 8040)
            $display("FAIL drain_rst_stale: writes=%0d required 1 (addr 8040 before reset)", obs_w.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) fb[i] = 3'd0;
        test_reset();
        test_single_plot();
        test_back_to_back();
        test_boundary();
        test_coherence();
        test_oor_query();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
